// File: rtl/sum_result_bcd_if.sv
// Bus between the summation unit (master) and the BCD converter (slave).
// With SUM_BCD_SEG_EN defined the bus also carries the 7-segment output.
`timescale 1ns/1ps
interface sum_result_bcd_if #(
  parameter int IN_W   = 13,
  parameter int DIGITS = 4
);
  logic                  finish_in;
  logic [IN_W-1:0]       result_in;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  valid;
  logic                  done;
  logic                  busy;
`ifdef SUM_BCD_SEG_EN
  logic [7*DIGITS-1:0]   seg_out;

  modport master (output finish_in, output result_in,
                  input bcd_out, input valid, input done, input busy, input seg_out);
  modport slave  (input finish_in, input result_in,
                  output bcd_out, output valid, output done, output busy, output seg_out);
`else
  modport master (output finish_in, output result_in,
                  input bcd_out, input valid, input done, input busy);
  modport slave  (input finish_in, input result_in,
                  output bcd_out, output valid, output done, output busy);
`endif
endinterface

// File: rtl/sum_result_bcd.sv
// Captures the summation result on the rising edge of finish_in and converts
// it to packed BCD with a sequential double-dabble, one shift per clock.
// Optional macro SUM_BCD_SEG_EN adds a registered 7-segment output (gfedcba).
`timescale 1ns/1ps
module sum_result_bcd #(
  parameter int IN_W   = 13,
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  sum_result_bcd_if.slave  bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int WRK_W = BCD_W + IN_W;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_finish_d;
  logic               w_trig;
  logic [CNT_W-1:0]   r_cnt;
  logic [WRK_W-1:0]   r_work;
  logic [WRK_W-1:0]   w_shifted;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_valid;
  logic               r_done;
  logic               r_busy;
  logic               w_load;
  logic               w_shift;
  logic               w_finish;

  // Add 3 to every scratch nibble >= 5, all nibbles judged on the pre-shift value
  function automatic logic [BCD_W-1:0] f_dabble_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] a;
    for (int d = 0; d < DIGITS; d++) begin
      a[4*d +: 4] = (s[4*d +: 4] >= 4'd5) ? (s[4*d +: 4] + 4'd3) : s[4*d +: 4];
    end
    return a;
  endfunction

  assign w_trig    = bus.finish_in & ~r_finish_d;
  assign w_shifted = {f_dabble_adjust(r_work[WRK_W-1 -: BCD_W]), r_work[IN_W-1:0]} << 1;

  // Delay finish_in by one clock in every state for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_finish_d <= 1'b0;
    else      r_finish_d <= bus.finish_in;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state: triggers are ignored outside IDLE, so nothing is queued
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_trig) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == CNT_W'(IN_W - 1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control decode from the current state
  always_comb begin
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE:  w_load   = w_trig;
      S_SHIFT: w_shift  = 1'b1;
      S_DONE:  w_finish = 1'b1;
      default: ;
    endcase
  end

  // Working register {scratch, bin} and iteration counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_work <= '0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_work <= {{BCD_W{1'b0}}, bus.result_in};
      r_cnt  <= '0;
    end else if (w_shift) begin
      r_work <= w_shifted;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Result registers: old bcd_out stays visible until the new result lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcd   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_valid <= 1'b0;
        r_busy  <= 1'b1;
      end
      if (w_finish) begin
        r_bcd   <= r_work[WRK_W-1 -: BCD_W];
        r_valid <= 1'b1;
        r_busy  <= 1'b0;
      end
    end
  end

  assign bus.bcd_out = r_bcd;
  assign bus.valid   = r_valid;
  assign bus.done    = r_done;
  assign bus.busy    = r_busy;

`ifdef SUM_BCD_SEG_EN
  logic [7*DIGITS-1:0] r_seg;

  // Active-high gfedcba pattern for one decimal digit
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Segment register updates on the same edge as bcd_out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg <= '0;
    end else if (w_finish) begin
      for (int d = 0; d < DIGITS; d++) begin
        r_seg[7*d +: 7] <= f_seg(r_work[IN_W + 4*d +: 4]);
      end
    end
  end

  assign bus.seg_out = r_seg;
`endif
endmodule

// File: tb/tb_sum_result_bcd.sv
// Randomized self-checking bench for sum_result_bcd against a decimal model.
`timescale 1ns/1ps
module tb_sum_result_bcd;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [15:0] prev_bcd = 16'h0;

  always #5 clk = ~clk;

  sum_result_bcd_if #(.IN_W(13), .DIGITS(4)) bus();
  sum_result_bcd #(.IN_W(13), .DIGITS(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Decimal digits by plain division
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

`ifdef SUM_BCD_SEG_EN
  function automatic logic [27:0] to_seg(input int v);
    logic [6:0] tbl [10];
    logic [27:0] r;
    int t;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[7*d +: 7] = tbl[t % 10];
      t = t / 10;
    end
    return r;
  endfunction
`endif

  // One conversion with full cycle-by-cycle checks; hold keeps finish_in high
  task automatic run_conv(input int v, input bit hold);
    logic [15:0] exp;
    exp = to_bcd(v);
    bus.finish_in = 1'b0;
    bus.result_in = 13'($urandom);
    @(negedge clk);
    bus.result_in = 13'(v);
    bus.finish_in = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) bus.result_in = 13'($urandom);
      if (!hold && i == 2) bus.finish_in = 1'b0;
      if (i <= 14) begin
        chk("busy_run", 32'(bus.busy), 32'd1);
        chk("valid_run", 32'(bus.valid), 32'd0);
        chk("done_run", 32'(bus.done), 32'd0);
        chk("bcd_hold", 32'(bus.bcd_out), 32'(prev_bcd));
      end else if (i == 15) begin
        chk("bcd", 32'(bus.bcd_out), 32'(exp));
        chk("valid", 32'(bus.valid), 32'd1);
        chk("done", 32'(bus.done), 32'd1);
        chk("busy_end", 32'(bus.busy), 32'd0);
`ifdef SUM_BCD_SEG_EN
        chk("seg", 32'(bus.seg_out), 32'(to_seg(v)));
`endif
      end else begin
        chk("done_pulse", 32'(bus.done), 32'd0);
        chk("valid_keep", 32'(bus.valid), 32'd1);
      end
    end
    prev_bcd = exp;
  endtask

  initial begin
    int n;
    logic [15:0] cap;
    bus.finish_in = 1'b0;
    bus.result_in = '0;
    #12;
    chk("rst_bcd", 32'(bus.bcd_out), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Main case and boundaries
    run_conv(5050, 1'b0);
    run_conv(0, 1'b0);
    run_conv(8191, 1'b0);
    run_conv(99, 1'b0);

    // Held-high finish_in: one conversion only
    run_conv(1999, 1'b1);
    n = 0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    chk("held_extra_done", 32'(n), 32'd0);
    chk("held_bcd", 32'(bus.bcd_out), 32'h1999);

    // Edge during SHIFT is ignored
    bus.finish_in = 1'b0;
    @(negedge clk);
    bus.result_in = 13'd777;
    bus.finish_in = 1'b1;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 2) bus.finish_in = 1'b0;
      if (i == 5) begin bus.finish_in = 1'b1; bus.result_in = 13'd4321; end
      if (i == 7) bus.finish_in = 1'b0;
      if (bus.done) n++;
    end
    chk("ign_dones", 32'(n), 32'd1);
    chk("ign_bcd", 32'(bus.bcd_out), 32'h0777);
    prev_bcd = 16'h0777;
    run_conv(4321, 1'b0);

    // Asynchronous reset in the middle of SHIFT
    bus.finish_in = 1'b0;
    @(negedge clk);
    bus.result_in = 13'd5050;
    bus.finish_in = 1'b1;
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 2) bus.finish_in = 1'b0;
    end
    chk("mid_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_bcd", 32'(bus.bcd_out), 32'd0);
    chk("mid_rst_valid", 32'(bus.valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    chk("mid_no_done", 32'(n), 32'd0);
    prev_bcd = 16'h0;
    run_conv(5050, 1'b0);

    // finish_in already high when reset releases
    @(negedge clk);
    rst = 1'b0;
    bus.result_in = 13'd1234;
    bus.finish_in = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    cap = 16'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) bus.result_in = 13'd42;
      if (bus.done) begin n++; cap = bus.bcd_out; end
    end
    chk("rel_dones", 32'(n), 32'd1);
    chk("rel_bcd", 32'(cap), 32'h1234);
    prev_bcd = 16'h1234;

    // Random values
    for (int k = 0; k < 20; k++) begin
      run_conv(int'($urandom_range(0, 8191)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
